countdown_arbiter: RTL
======================

Name: countdown_arbiter

Overview:
- Shares one CNT_W-bit down-counter among N_REQ requesters that each need a timed interval.
- Round-robin arbiter picks a requester, loads its interval length, counts down to zero, then pulses that requester's done.
- Sits between timer clients (blink, debounce, timeout logic) and the single countdown datapath on the FPGA board.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CNT_W, 4, counter width; max interval length 2^CNT_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N_REQ  per-requester interval request, level.
- len  in  N_REQ*CNT_W  per-requester interval length; slice i = len[i*CNT_W +: CNT_W].
- grant  out  N_REQ  one-hot; owner of the counter, or zero.
- done  out  N_REQ  one-cycle pulse to the owner at interval end.
- busy  out  1  high whenever state != IDLE.
- count  out  CNT_W  current counter value, for debug and LEDs.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, count=all-ones, grant=0, done=0, busy=0.
  - Round-robin pointer set so requester 0 has highest priority first.
- Clean exit: deassertion takes effect on the next clk edge.
- FSM states: IDLE, LOAD, COUNT, DONE.
- IDLE:
  - If any req bit is set, select the first set bit searching upward from (last winner+1) mod N_REQ, wrapping.
  - Latch the winner index and go to LOAD.
  - If no req, stay in IDLE; count holds its value.
- LOAD (1 cycle):
  - grant[idx]=1 and busy=1.
  - count <= len slice of idx; len is sampled only in this cycle.
  - Go to COUNT.
- COUNT:
  - If count==0, go to DONE.
  - Otherwise count <= count-1; no wrap occurs because 0 is the exit condition.
- DONE (1 cycle):
  - done[idx]=1, grant[idx] still 1.
  - Update the round-robin pointer to idx; go to IDLE.
- grant is high from LOAD through DONE inclusive and low in IDLE.
- Latency: req seen in IDLE at edge t → grant at t+1, count=L at t+2, count=0 at t+2+L, done at t+3+L, IDLE at t+4+L.
  - Total owner time is L+3 cycles.
- len=0: one COUNT cycle at 0, then DONE.
- Requester must drop req in the done cycle; a req still high in IDLE re-enters arbitration as a new request, at the lowest priority.
- Simultaneous requests: exactly one is granted; others wait. No starvation: every waiting requester is served within N_REQ grants.
- req changes while not owner: ignored until IDLE.
- Owner drops req during LOAD/COUNT with the macro undefined: no effect, interval completes.
- rst mid-interval: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: COUNTDOWN_ARBITER_ABORT_EN.
- Defined: if the owner's req is 0 in LOAD or COUNT, next state is IDLE.
  - No done pulse; grant drops; count holds its value.
  - Round-robin pointer updates to idx as if completed.
- Undefined: req is ignored after arbitration; the interval always completes.

Decomposition:
- Shared package countdown_pkg:
  - state enum (IDLE, LOAD, COUNT, DONE).
  - Default N_REQ and CNT_W constants.
  - Helper function for the round-robin next-index search.
- One sub-module: cd_datapath.
  - CNT_W register with async reset to all-ones, load (with value) and dec controls, zero flag.
  - The controller drives load/dec only.

Test Plan:
- Reset: rst=1 mid-COUNT (count=5) → grant=0, done=0, busy=0, count=4'hF same cycle; after release with req=0, stays IDLE.
- Single request: req=4'b0001, len0=3 at edge t → grant=0001 at t+1, count sequence 3,2,1,0, done=0001 pulse at t+6, busy low at t+7.
- Zero length: req=4'b0100, len2=0 → grant=0100, count 0 for one cycle, done pulse at t+3.
- Round-robin: req=4'b1111 held, all len=1 → grant order 0,1,2,3,0; each done pulse exactly 1 cycle.
- Contention after owner finishes: owner 1 keeps req high after done while req3 waits → requester 3 is granted next.
- Abort (macro defined): req0 dropped when count=2 → next cycle IDLE, no done, grant=0, count stays 2. With macro undefined, the same stimulus completes and pulses done0.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and helpers for the countdown arbiter.
// Abort-on-drop is enabled by COUNTDOWN_ARBITER_ABORT_EN.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COUNT,
    DONE
  } state_t;

  localparam int N_REQ_DEF = 4;
  localparam int CNT_W_DEF = 4;

  // First set bit above last, wrapping; last itself is lowest priority.
  function automatic logic [2:0] rr_pick(
    input logic [7:0] r,
    input logic [2:0] last,
    input int         n
  );
    logic [2:0] pick;
    logic [2:0] j;
    pick = last;
    for (int i = n; i >= 1; i--) begin
      j = 3'((int'(last) + i) % n);
      if (r[j]) pick = j;
    end
    return pick;
  endfunction

endpackage

// File: rtl/cd_datapath.sv
// Shared down-counter: load, decrement and zero flag.
// Resets to all-ones.
module cd_datapath
  import countdown_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] value,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '1;
    else if (load) count <= value;
    else if (dec)  count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/countdown_arbiter.sv
// Round-robin arbiter sharing one down-counter among requesters.
// Define COUNTDOWN_ARBITER_ABORT_EN to let the owner abort by dropping req.
module countdown_arbiter
  import countdown_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] len,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [CNT_W-1:0]       count
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] pick;
  logic             keep;
  logic             load;
  logic             dec;
  logic             zero;
  logic [CNT_W-1:0] value;

  assign pick = IDX_W'(rr_pick(8'(req), 3'(last), N_REQ));

`ifdef COUNTDOWN_ARBITER_ABORT_EN
  assign keep = req[idx];
`else
  assign keep = 1'b1;
`endif

  assign value = len[idx*CNT_W +: CNT_W];
  assign load  = (state == LOAD) && keep;
  assign dec   = (state == COUNT) && keep && !zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      last  <= IDX_W'(N_REQ - 1);
      grant <= '0;
      done  <= '0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            idx   <= pick;
            grant <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD, COUNT: begin
          if (!keep) begin
            grant <= '0;
            busy  <= 1'b0;
            last  <= idx;
            state <= IDLE;
          end else if (state == LOAD) begin
            state <= COUNT;
          end else if (zero) begin
            done  <= grant;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= '0;
          grant <= '0;
          busy  <= 1'b0;
          last  <= idx;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  cd_datapath #(
    .CNT_W(CNT_W)
  ) u_dp (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .dec  (dec),
    .value(value),
    .count(count),
    .zero (zero)
  );

endmodule
